fifo_threshold: RTL and testbench
=================================

Name: fifo_threshold

Overview:
- Single-clock synchronous FIFO with programmable almost-full/almost-empty thresholds.
- It is the far end of the state-machine control interface. It consumes sup_threshold, inf_threshold and reset_L from the controller, and returns its empty flag as one bit of the controller's 8-bit empties bus.
- Eight instances sit in the datapath, one per empties bit.
- Flow-control flags feed the upstream pause logic and the downstream arbiter.

Parameters:
- DATA_WIDTH, 10, width of each stored word.
- DEPTH, 8, number of entries; must be a power of two and at most 8, to match the 3-bit thresholds.
- ADDR_WIDTH, 3, log2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- reset_L  in  1  controller soft-enable; low = hold FIFO cleared
- sup_threshold  in  3  almost-full level from controller
- inf_threshold  in  3  almost-empty level from controller
- push  in  1  write request
- data_in  in  DATA_WIDTH  write data
- pop  in  1  read request
- data_out  out  DATA_WIDTH  registered read data
- valid_out  out  1  data_out holds a word popped on the previous cycle
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- empty  out  1  count==0; drives the controller's empties bit
- full  out  1  count==DEPTH
- almost_full  out  1  count >= sup_threshold
- almost_empty  out  1  count <= inf_threshold
- error  out  1  sticky overflow/underflow indicator

Behaviour:
- Clocking and clear:
  - All state updates on posedge clk.
  - reset=1 has priority over everything.
  - reset=1 or reset_L=0 clears wr_ptr, rd_ptr, count, data_out, valid_out and error to 0.
  - While cleared: empty=1, full=0, almost_empty=1, and almost_full=1 only if sup_threshold==0.
  - Memory contents are not cleared.
  - push/pop are ignored while reset=1 or reset_L=0.
- Write: push accepted when push=1 and (count<DEPTH or a pop is accepted in the same cycle). data_in is stored at wr_ptr, then wr_ptr increments modulo DEPTH.
- Read:
  - pop accepted when pop=1 and count>0.
  - The word at rd_ptr is registered into data_out at that edge, and rd_ptr increments modulo DEPTH. Read latency is one cycle.
  - valid_out=1 in the cycle after an accepted pop, else 0.
  - data_out holds its last value when no pop is accepted.
- Count: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
- Simultaneous push+pop:
  - When full: both accepted, count stays DEPTH, no error.
  - When empty: push accepted, pop rejected (no bypass), error set.
- Error:
  - Set by push with count==DEPTH and no accepted pop (write dropped).
  - Set by pop with count==0 (read dropped).
  - Stays 1 until reset or reset_L=0.
- Flags:
  - empty, full, almost_full and almost_empty are combinational from the count register and the threshold inputs, with zero latency after a threshold change.
  - Thresholds are compared zero-extended to count width.
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap naturally. Occupancy comes from the count register only, never from pointer difference.
- reset_L deasserted mid-operation: the FIFO flushes on that edge; in-flight push/pop that cycle are discarded.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DEPTH=8, FIFO_ADDR_WIDTH=3, FIFO_DATA_WIDTH=10, THRESH_WIDTH=3.
  - Controller state encodings RESET/INIT/IDLE/ACTIVE (one-hot 4'b0001/0010/0100/1000), used by the bench to sequence.
- Sub-module fifo_mem: DEPTH x DATA_WIDTH register file with a synchronous write port and an asynchronous read port addressed by rd_ptr. fifo_threshold registers the read output.

Test Plan:
- Reset, then reset_L=1 with sup=6, inf=1 -> count=0, empty=1, almost_empty=1, almost_full=0, full=0, error=0, valid_out=0.
- Push 0x001..0x008 on 8 consecutive cycles -> almost_empty drops when count=2, almost_full rises when count=6, full=1 when count=8, empty=0. Then pop 8 times -> data_out 0x001..0x008 each one cycle after its pop, with valid_out=1.
- At count=8, push 0x3FF without pop -> count stays 8, error=1, later pops never return 0x3FF. Separately, at count=8 push 0x155 with pop -> count 8, error 0, 0x155 appears after the 7 older words.
- At count=0, assert pop alone -> error=1, valid_out=0. At count=0, push+pop -> count=1, error=1, pop rejected.
- Fill 3 words, pop 3, push 6 more to force pointer wrap -> data order preserved across the wrap and count=6. Then change sup_threshold 6->7 -> almost_full falls in the same cycle.
- With count=5, drop reset_L for one cycle while pushing -> next cycle count=0, empty=1, error=0, the push is discarded, and the controller's empties bit reads 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the threshold FIFO and the controller that sequences it:
// default geometry, threshold width and the controller's one-hot state encodings.
package fifo_pkg;

   localparam int FIFO_DEPTH      = 8;
   localparam int FIFO_ADDR_WIDTH = 3;
   localparam int FIFO_DATA_WIDTH = 10;
   localparam int THRESH_WIDTH    = 3;

   // The controller walks RESET -> INIT -> IDLE -> ACTIVE and enables the FIFOs in ACTIVE.
   typedef enum logic [3:0] {
      RESET  = 4'b0001,
      INIT   = 4'b0010,
      IDLE   = 4'b0100,
      ACTIVE = 4'b1000
   } ctrl_state_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; occupancy tracking lives in the FIFO control.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_threshold.sv
// Single-clock FIFO with programmable almost-full / almost-empty levels and a sticky
// overflow/underflow error; occupancy is held in an explicit count register.
module fifo_threshold
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reset_L,
   input  logic [THRESH_WIDTH-1:0] sup_threshold,
   input  logic [THRESH_WIDTH-1:0] inf_threshold,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    valid_out,
   output logic [ADDR_WIDTH:0]     count,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic                    error
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  clear;
   logic                  pop_ok;
   logic                  push_ok;
   logic                  overflow;
   logic                  underflow;

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
   always_comb begin
      clear     = reset | ~reset_L;
      pop_ok    = pop && (count != '0);
      push_ok   = push && ((count < FULL_COUNT) || pop_ok);
      overflow  = push && (count == FULL_COUNT) && !pop_ok;
      underflow = pop && (count == '0);
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk        (clk),
      .write_en   (push_ok & ~clear),
      .write_addr (wr_ptr),
      .write_data (data_in),
      .read_addr  (rd_ptr),
      .read_data  (rd_word)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         error     <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            data_out <= rd_word;
            rd_ptr   <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
         if (overflow || underflow) begin
            error <= 1'b1;
         end
      end
   end

   // Flags follow threshold changes immediately, so they stay combinational off count.
   assign empty        = (count == '0);
   assign full         = (count == FULL_COUNT);
   assign almost_full  = (count >= (ADDR_WIDTH+1)'(sup_threshold));
   assign almost_empty = (count <= (ADDR_WIDTH+1)'(inf_threshold));

endmodule

// File: tb/tb_fifo_threshold.sv
// Self-checking bench for fifo_threshold: directed vector table, corner-case sequences
// and randomized traffic, all compared against a queue-based reference model.
module tb_fifo_threshold;
   import fifo_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       reset_L;
   logic [2:0] sup_threshold;
   logic [2:0] inf_threshold;
   logic       push;
   logic [9:0] data_in;
   logic       pop;
   logic [9:0] data_out;
   logic       valid_out;
   logic [3:0] count;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic       almost_empty;
   logic       error;
   logic [7:0] empties;

   ctrl_state_t ctrl_state;

   int errors = 0;
   int checks = 0;

   int m_q[$];
   int m_dout;
   bit m_valid;
   bit m_err;

   typedef struct {
      bit         rl;
      bit         pu;
      bit         po;
      logic [9:0] din;
      int         cnt;
      bit         vld;
      logic [9:0] dout;
      bit         err;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   assign reset_L = (ctrl_state == ACTIVE);
   assign empties = {7'b0, empty};

   fifo_threshold dut (
      .clk           (clk),
      .reset         (reset),
      .reset_L       (reset_L),
      .sup_threshold (sup_threshold),
      .inf_threshold (inf_threshold),
      .push          (push),
      .data_in       (data_in),
      .pop           (pop),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .count         (count),
      .empty         (empty),
      .full          (full),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .error         (error)
   );

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour expressed on a queue of words, using the occupancy before the edge.
   task automatic modelStep(input bit rst, input bit rl, input bit pu, input bit po, input int din);
      int n;
      bit pop_ok;
      bit push_ok;
      n = m_q.size();
      if (rst || !rl) begin
         m_q.delete();
         m_dout  = 0;
         m_valid = 0;
         m_err   = 0;
      end else begin
         pop_ok  = po && (n > 0);
         push_ok = pu && ((n < 8) || pop_ok);
         m_valid = pop_ok;
         if (pop_ok) m_dout = m_q.pop_front();
         if (push_ok) m_q.push_back(din);
         if (po && n == 0) m_err = 1;
         if (pu && n == 8 && !pop_ok) m_err = 1;
      end
   endtask

   task automatic checkOutput();
      int n;
      n = m_q.size();
      checkValue("model count", count, n);
      checkValue("model empty", empty, n == 0);
      checkValue("model full", full, n == 8);
      checkValue("model almost_full", almost_full, n >= int'(sup_threshold));
      checkValue("model almost_empty", almost_empty, n <= int'(inf_threshold));
      checkValue("model valid_out", valid_out, m_valid);
      checkValue("model data_out", data_out, m_dout);
      checkValue("model error", error, m_err);
   endtask

   task automatic applyStimulus(input bit rl, input bit pu, input bit po, input logic [9:0] din);
      ctrl_state = rl ? ACTIVE : IDLE;
      push       = pu;
      pop        = po;
      data_in    = din;
      @(posedge clk);
      modelStep(reset, rl, pu, po, int'(din));
      #1;
      checkOutput();
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_state    = RESET;
      sup_threshold = 3'd6;
      inf_threshold = 3'd1;
      push          = 1'b0;
      pop           = 1'b0;
      data_in       = '0;
      m_q.delete();
      m_dout  = 0;
      m_valid = 0;
      m_err   = 0;

      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
      ctrl_state = INIT;
      applyStimulus(1'b1, 1'b0, 1'b0, 10'h0);
      reset = 1'b0;
      ctrl_state = ACTIVE;
      #1;
      checkValue("reset count", count, 0);
      checkValue("reset empty", empty, 1);
      checkValue("reset almost_empty", almost_empty, 1);
      checkValue("reset almost_full", almost_full, 0);
      checkValue("reset full", full, 0);
      checkValue("reset error", error, 0);
      checkValue("reset valid_out", valid_out, 0);

      // Directed table: fill, drain, underflow, push+pop on empty, soft clear while pushing.
      for (int i = 1; i <= 8; i++)
         vecs.push_back('{1, 1, 0, 10'(i), i, 0, 10'h000, 0});
      for (int i = 1; i <= 8; i++)
         vecs.push_back('{1, 0, 1, 10'h000, 8 - i, 1, 10'(i), 0});
      vecs.push_back('{1, 0, 1, 10'h000, 0, 0, 10'h008, 1});
      vecs.push_back('{1, 1, 1, 10'h0AA, 1, 0, 10'h008, 1});
      vecs.push_back('{0, 1, 0, 10'h0BB, 0, 0, 10'h000, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rl, vecs[i].pu, vecs[i].po, vecs[i].din);
         checkValue($sformatf("vec%0d count", i), count, vecs[i].cnt);
         checkValue($sformatf("vec%0d valid_out", i), valid_out, vecs[i].vld);
         checkValue($sformatf("vec%0d data_out", i), data_out, vecs[i].dout);
         checkValue($sformatf("vec%0d error", i), error, vecs[i].err);
         if (i == 1) checkValue("ae drops at 2", almost_empty, 0);
         if (i == 5) checkValue("af rises at 6", almost_full, 1);
         if (i == 7) checkValue("full at 8", full, 1);
      end

      // Overflow: the dropped word must never come back out.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 10'(16 + i));
      applyStimulus(1'b1, 1'b1, 1'b0, 10'h3FF);
      checkValue("ovf count", count, 8);
      checkValue("ovf error", error, 1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 10'h0);
         checkValue("ovf pop data", data_out, 16 + i);
      end
      checkValue("ovf error sticky", error, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);

      // Push+pop while full: new word lands behind the seven older ones.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 10'(32 + i));
      applyStimulus(1'b1, 1'b1, 1'b1, 10'h155);
      checkValue("full pp count", count, 8);
      checkValue("full pp error", error, 0);
      checkValue("full pp data", data_out, 32);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 10'h0);
         checkValue("full pp older data", data_out, 32 + i);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 10'h0);
      checkValue("full pp new word", data_out, 10'h155);
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);

      // Pointer wrap, then a threshold change that must move almost_full with no clock.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 10'(64 + i));
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 10'h0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 10'(80 + i));
      checkValue("wrap count", count, 6);
      checkValue("wrap af at sup6", almost_full, 1);
      sup_threshold = 3'd7;
      #1;
      checkValue("wrap af at sup7", almost_full, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 10'h0);
         checkValue("wrap order", data_out, 80 + i);
      end
      sup_threshold = 3'd6;

      // Soft clear at count=5 with a push in flight.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 10'(96 + i));
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h2AA);
      checkValue("softclr count", count, 0);
      checkValue("softclr empty", empty, 1);
      checkValue("softclr error", error, 0);
      checkValue("softclr empties bit", empties[0], 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 10'h0);
      checkValue("softclr push discarded", valid_out, 0);

      // Held clear with a zero almost-full level.
      sup_threshold = 3'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h0);
      checkValue("cleared af sup0", almost_full, 1);
      checkValue("cleared ae", almost_empty, 1);
      sup_threshold = 3'd6;

      // Randomized traffic with drifting thresholds and rare soft clears.
      for (int i = 0; i < 600; i++) begin
         bit rl;
         bit pu;
         bit po;
         if (i % 16 == 0) begin
            sup_threshold = 3'($urandom_range(0, 7));
            inf_threshold = 3'($urandom_range(0, 7));
         end
         rl = ($urandom_range(0, 40) != 0);
         if ((i / 64) % 2 == 0) begin
            pu = ($urandom_range(0, 3) != 0);
            po = ($urandom_range(0, 3) == 0);
         end else begin
            pu = ($urandom_range(0, 3) == 0);
            po = ($urandom_range(0, 3) != 0);
         end
         applyStimulus(rl, pu, po, 10'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
